// File: rtl/seg_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// seg_ctrl_pkg
// Shared constants for the SPI-fed seven-segment multiplex controller:
// frame width and field positions, the control-frame address, bit-counter
// limits and the segment bit order on seg_out.
// -----------------------------------------------------------------------------
package seg_ctrl_pkg;

   localparam int FRAME_W   = 16;

   // Frame layout: [15:12] address, [11:9] reserved, [8] blink, [7:0] pattern
   localparam int ADDR_MSB  = 15;
   localparam int ADDR_LSB  = 12;
   localparam int RSVD_MSB  = 11;
   localparam int RSVD_LSB  = 9;
   localparam int BLINK_BIT = 8;
   localparam int PAT_MSB   = 7;
   localparam int PAT_LSB   = 0;

   localparam logic [3:0] ADDR_CTRL = 4'hF;

   // Bit counter saturates one past a full frame so over-long frames stay bad
   localparam int                   BIT_CNT_W    = 5;
   localparam logic [BIT_CNT_W-1:0] BIT_CNT_FULL = 5'd16;
   localparam logic [BIT_CNT_W-1:0] BIT_CNT_SAT  = 5'd17;

   // Segment bit order on seg_out (active high)
   typedef enum logic [2:0] {
      SEG_A  = 3'd0,
      SEG_B  = 3'd1,
      SEG_C  = 3'd2,
      SEG_D  = 3'd3,
      SEG_E  = 3'd4,
      SEG_F  = 3'd5,
      SEG_G  = 3'd6,
      SEG_DP = 3'd7
   } seg_bit_e;

endpackage

// File: rtl/spi_frame_rx.sv
// -----------------------------------------------------------------------------
// spi_frame_rx
// SPI mode-0 frame receiver running entirely in the clk domain.
// Ports:
//   clk_i, rst_i       system clock, synchronous active-high reset
//   spi_sclk_i         SPI clock pin (asynchronous, <= clk/4)
//   spi_cs_n_i         SPI chip select pin, active low
//   spi_mosi_i         SPI data pin, MSB first
//   frame_valid_o      1-cycle: cs_n rose after exactly FRAME_W bits
//   frame_bad_o        1-cycle: cs_n rose after any other bit count
//   frame_o            last FRAME_W bits shifted in
// -----------------------------------------------------------------------------
module spi_frame_rx
   import seg_ctrl_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               spi_sclk_i,
   input  logic               spi_cs_n_i,
   input  logic               spi_mosi_i,
   output logic               frame_valid_o,
   output logic               frame_bad_o,
   output logic [FRAME_W-1:0] frame_o
);

   logic [1:0]           sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic                 sclk_dly_q, cs_n_dly_q;
   logic                 active_q, active_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [FRAME_W-1:0]   shift_q, shift_d;
   logic                 sclk_rise, cs_fall, cs_rise;

   assign sclk_rise = sclk_sync_q[1] & ~sclk_dly_q;
   assign cs_fall   = ~cs_sync_q[1] & cs_n_dly_q;
   assign cs_rise   = cs_sync_q[1] & ~cs_n_dly_q;

   // A frame is only tracked from a cs_n fall seen after reset, so a frame
   // cut by reset ends silently instead of raising frame_bad.
   always_comb begin
      // NOTE: every next-state value gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      active_d  = active_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      if (cs_fall) begin
         active_d  = 1'b1;
         bit_cnt_d = '0;
         shift_d   = '0;
      end else if (cs_rise) begin
         active_d  = 1'b0;
      end else if (active_q && sclk_rise) begin
         shift_d = {shift_q[FRAME_W-2:0], mosi_sync_q[1]};
         if (bit_cnt_q != BIT_CNT_SAT) begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // cs_n sync resets to "selected": a high pin then shows a rise,
         // which is ignored because no frame is active.
         sclk_sync_q <= '0;
         cs_sync_q   <= '0;
         mosi_sync_q <= '0;
         sclk_dly_q  <= 1'b0;
         cs_n_dly_q  <= 1'b0;
         active_q    <= 1'b0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
      end else begin
         // NOTE: flops use non-blocking '<=' so every register samples the
         // pre-edge values; the always_comb above uses blocking '='.
         sclk_sync_q <= {sclk_sync_q[0], spi_sclk_i};
         cs_sync_q   <= {cs_sync_q[0], spi_cs_n_i};
         mosi_sync_q <= {mosi_sync_q[0], spi_mosi_i};
         sclk_dly_q  <= sclk_sync_q[1];
         cs_n_dly_q  <= cs_sync_q[1];
         active_q    <= active_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
      end
   end

   assign frame_valid_o = cs_rise & active_q & (bit_cnt_q == BIT_CNT_FULL);
   assign frame_bad_o   = cs_rise & active_q & (bit_cnt_q != BIT_CNT_FULL);
   assign frame_o       = shift_q;

endmodule

// File: rtl/spi_seg_mux_controller.sv
// -----------------------------------------------------------------------------
// spi_seg_mux_controller
// Multi-digit seven-segment controller: SPI frames write a per-digit segment
// RAM (or the display-enable control word at address 4'hF), and a prescaled
// scan multiplexes the RAM onto a shared segment bus with one-hot enables.
// Ports:
//   clk_i, rst_i        system clock, synchronous active-high reset
//   spi_sclk_i          SPI clock (mode 0, asynchronous)
//   spi_cs_n_i          SPI chip select, active low
//   spi_mosi_i          SPI data, MSB first
//   seg_out_o[7:0]      segments, bit 7 = dp, bits 6..0 = g..a
//   dig_en_o            one-hot digit enable (all zero when display is off)
//   frame_ok_o          1-cycle pulse when a frame is applied
//   frame_err_o         1-cycle pulse when a frame is discarded
// Build option: define SEG_BLINK_EN to add per-digit blinking, toggled every
// BLINK_DIV completed scan rounds; frame bit 8 sets the digit's blink bit.
// -----------------------------------------------------------------------------
module spi_seg_mux_controller
   import seg_ctrl_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int REFRESH_COUNT = 16,
   parameter int BLINK_DIV     = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  spi_sclk_i,
   input  logic                  spi_cs_n_i,
   input  logic                  spi_mosi_i,
   output logic [7:0]            seg_out_o,
   output logic [NUM_DIGITS-1:0] dig_en_o,
   output logic                  frame_ok_o,
   output logic                  frame_err_o
);

   localparam int               DIG_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int               PRE_W     = $clog2(REFRESH_COUNT);
   localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(NUM_DIGITS - 1);
   localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_COUNT - 1);
   localparam logic [3:0]       NUM_DIG_A = 4'(NUM_DIGITS);

   logic               frame_valid, frame_bad;
   logic [FRAME_W-1:0] frame;
   logic [3:0]         frame_addr;
   logic [7:0]         frame_pat;
   logic               frame_blink;

   spi_frame_rx u_rx (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .spi_sclk_i    (spi_sclk_i),
      .spi_cs_n_i    (spi_cs_n_i),
      .spi_mosi_i    (spi_mosi_i),
      .frame_valid_o (frame_valid),
      .frame_bad_o   (frame_bad),
      .frame_o       (frame)
   );

   assign frame_addr  = frame[ADDR_MSB:ADDR_LSB];
   assign frame_pat   = frame[PAT_MSB:PAT_LSB];
   assign frame_blink = frame[BLINK_BIT];

   logic [7:0]            ram_q [NUM_DIGITS];
   logic [7:0]            ram_d [NUM_DIGITS];
   logic                  display_en_q, display_en_d;
   logic                  frame_ok_q, frame_ok_d, frame_err_q, frame_err_d;
   logic [PRE_W-1:0]      pre_q, pre_d;
   logic [DIG_W-1:0]      digit_q, digit_d;
   logic [7:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
   logic                  pre_wrap;
   logic                  frame_is_digit, frame_is_ctrl;

   assign pre_wrap       = (pre_q == PRE_LAST);
   assign frame_is_digit = (frame_addr < NUM_DIG_A);
   assign frame_is_ctrl  = (frame_addr == ADDR_CTRL);

`ifdef SEG_BLINK_EN
   localparam int               RND_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [RND_W-1:0] RND_LAST = RND_W'(BLINK_DIV - 1);

   logic [NUM_DIGITS-1:0] blink_q, blink_d;
   logic [RND_W-1:0]      round_q, round_d;
   logic                  blink_off_q, blink_off_d;
   logic                  unused_frame_bits;

   assign unused_frame_bits = ^frame[RSVD_MSB:RSVD_LSB];
`else
   logic unused_frame_bits;

   assign unused_frame_bits = ^{frame[RSVD_MSB:RSVD_LSB], frame_blink, BLINK_DIV[0]};
`endif

   // Frame application: RAM write, control write, or discard
   always_comb begin
      ram_d        = ram_q;
      display_en_d = display_en_q;
      frame_ok_d   = 1'b0;
      frame_err_d  = frame_bad;
`ifdef SEG_BLINK_EN
      blink_d      = blink_q;
`endif
      if (frame_valid) begin
         if (frame_is_digit) begin
            ram_d[frame_addr[DIG_W-1:0]] = frame_pat;
`ifdef SEG_BLINK_EN
            blink_d[frame_addr[DIG_W-1:0]] = frame_blink;
`endif
            frame_ok_d = 1'b1;
         end else if (frame_is_ctrl) begin
            display_en_d = frame_pat[0];
            frame_ok_d   = 1'b1;
         end else begin
            frame_err_d  = 1'b1;
         end
      end
   end

   // Scan: prescaler and digit index keep running while the display is off
   always_comb begin
      pre_d   = pre_wrap ? '0 : pre_q + PRE_W'(1);
      digit_d = digit_q;
      if (pre_wrap) begin
         digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DIG_W'(1);
      end
   end

`ifdef SEG_BLINK_EN
   // Blink phase toggles after every BLINK_DIV completed scan rounds
   always_comb begin
      round_d     = round_q;
      blink_off_d = blink_off_q;
      if (pre_wrap && (digit_q == DIG_LAST)) begin
         if (round_q == RND_LAST) begin
            round_d     = '0;
            blink_off_d = ~blink_off_q;
         end else begin
            round_d     = round_q + RND_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         blink_q     <= '0;
         round_q     <= '0;
         blink_off_q <= 1'b0;
      end else begin
         blink_q     <= blink_d;
         round_q     <= round_d;
         blink_off_q <= blink_off_d;
      end
   end
`endif

   // Registered outputs follow the current digit one clk later
   always_comb begin
      seg_d    = '0;
      dig_en_d = '0;
      if (display_en_q) begin
         seg_d    = ram_q[digit_q];
         dig_en_d = NUM_DIGITS'(1) << digit_q;
`ifdef SEG_BLINK_EN
         if (blink_off_q && blink_q[digit_q]) begin
            seg_d = '0;
         end
`endif
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // NOTE: the segment RAM is reset on purpose so a fresh display is
         // blank; storage that needs no defined start value would skip this.
         for (int i = 0; i < NUM_DIGITS; i++) begin
            ram_q[i] <= '0;
         end
         display_en_q <= 1'b1;
         frame_ok_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         pre_q        <= '0;
         digit_q      <= '0;
         seg_q        <= '0;
         dig_en_q     <= NUM_DIGITS'(1);
      end else begin
         ram_q        <= ram_d;
         display_en_q <= display_en_d;
         frame_ok_q   <= frame_ok_d;
         frame_err_q  <= frame_err_d;
         pre_q        <= pre_d;
         digit_q      <= digit_d;
         seg_q        <= seg_d;
         dig_en_q     <= dig_en_d;
      end
   end

   assign seg_out_o   = seg_q;
   assign dig_en_o    = dig_en_q;
   assign frame_ok_o  = frame_ok_q;
   assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_spi_seg_mux_controller.sv
// -----------------------------------------------------------------------------
// tb_spi_seg_mux_controller
// Directed SPI frames against spi_seg_mux_controller (4 digits, 16-cycle
// refresh, BLINK_DIV 2). A reference model derives the expected scan position
// from the number of clocks since reset and tracks RAM/control contents from
// the frames sent; every cycle's outputs are compared against it. Literal
// expectations at key points pin the model.
// -----------------------------------------------------------------------------
module tb_spi_seg_mux_controller;

   localparam int N  = 4;
   localparam int R  = 16;
   localparam int BD = 2;

`ifdef SEG_BLINK_EN
   localparam bit BLINK_BUILT = 1'b1;
`else
   localparam bit BLINK_BUILT = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst, sclk, cs_n, mosi;
   logic [7:0]   seg;
   logic [N-1:0] dig;
   logic         ok, err;

   always #5 clk = ~clk;

   spi_seg_mux_controller #(
      .NUM_DIGITS    (N),
      .REFRESH_COUNT (R),
      .BLINK_DIV     (BD)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .spi_sclk_i  (sclk),
      .spi_cs_n_i  (cs_n),
      .spi_mosi_i  (mosi),
      .seg_out_o   (seg),
      .dig_en_o    (dig),
      .frame_ok_o  (ok),
      .frame_err_o (err)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Frame hand-off from stimulus to model: applied at posedge number tx_stamp
   int          cyc      = 0;
   int          tx_seq   = 0;
   int          tx_stamp = 0;
   int          tx_bits  = 0;
   logic [15:0] tx_frame = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         if (n_errors <= 40) begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
         end
      end
   endtask

   // ---------------------------------------------------------------- model
   initial begin : model_check
      logic [7:0]   m_ram [N];
      bit           m_blink [N];
      bit           m_en;
      int           k;
      int           seen;
      int           d;
      int           a;
      bit           off;
      bit           started;
      logic [7:0]   e_seg;
      logic [N-1:0] e_dig;
      logic         e_ok, e_err;
      started = 1'b0;
      seen    = 0;
      k       = 0;
      m_en    = 1'b1;
      for (int i = 0; i < N; i++) begin
         m_ram[i]   = '0;
         m_blink[i] = 1'b0;
      end
      forever begin
         @(posedge clk);
         cyc++;
         e_ok  = 1'b0;
         e_err = 1'b0;
         if (rst) begin
            started = 1'b1;
            k       = 0;
            m_en    = 1'b1;
            seen    = tx_seq;
            for (int i = 0; i < N; i++) begin
               m_ram[i]   = '0;
               m_blink[i] = 1'b0;
            end
            e_seg = '0;
            e_dig = N'(1);
         end else begin
            // Outputs after this edge show the digit selected k clocks in
            d     = (k / R) % N;
            off   = (((k / (N * R)) / BD) % 2) == 1;
            e_dig = m_en ? (N'(1) << d) : '0;
            e_seg = '0;
            if (m_en) begin
               e_seg = (BLINK_BUILT && off && m_blink[d]) ? 8'h00 : m_ram[d];
            end
            if (tx_seq != seen && cyc == tx_stamp) begin
               seen = tx_seq;
               a    = int'(tx_frame[15:12]);
               if (tx_bits != 16) begin
                  e_err = 1'b1;
               end else if (a < N) begin
                  m_ram[a]   = tx_frame[7:0];
                  m_blink[a] = tx_frame[8];
                  e_ok       = 1'b1;
               end else if (a == 15) begin
                  m_en = tx_frame[0];
                  e_ok = 1'b1;
               end else begin
                  e_err = 1'b1;
               end
            end
            k++;
         end
         #1;
         if (started) begin
            check("cyc_seg_out", 32'(seg), 32'(e_seg));
            check("cyc_dig_en", 32'(dig), 32'(e_dig));
            check("cyc_frame_ok", 32'(ok), 32'(e_ok));
            check("cyc_frame_err", 32'(err), 32'(e_err));
         end
      end
   end

   // ------------------------------------------------------------ stimulus
   task automatic shift_bits(input logic [31:0] data, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) begin
         mosi = data[i];
         repeat (3) @(negedge clk);
         sclk = 1'b1;
         repeat (3) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [31:0] data, input int nbits,
                             input logic exp_ok, input logic exp_err, input string name);
      @(negedge clk);
      cs_n = 1'b0;
      repeat (4) @(negedge clk);
      shift_bits(data, nbits);
      repeat (4) @(negedge clk);
      cs_n     = 1'b1;
      tx_frame = data[15:0];
      tx_bits  = nbits;
      tx_stamp = cyc + 3;
      tx_seq++;
      // Pulse must appear exactly on the 3rd clk after the cs_n rise
      for (int e = 1; e <= 4; e++) begin
         @(posedge clk);
         #1;
         check({name, "_ok"}, 32'(ok), 32'((e == 3) ? exp_ok : 1'b0));
         check({name, "_err"}, 32'(err), 32'((e == 3) ? exp_err : 1'b0));
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_dig(input logic [N-1:0] target, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (dig === target) break;
      end
      check("wait_dig", 32'(dig), 32'(target));
   endtask

   initial begin : stimulus
      logic [N-1:0] step_tab [5];
      step_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rst  = 1'b1;
      cs_n = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_seg", 32'(seg), 32'h00);
      check("rst_dig", 32'(dig), 32'h1);
      check("rst_ok", 32'(ok), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Idle scan: dig_en steps every 16 clocks, segments stay dark
      for (int i = 0; i < 5; i++) begin
         repeat ((i == 0) ? 8 : 16) @(posedge clk);
         #1;
         check("scan_step", 32'(dig), 32'(step_tab[i]));
         check("idle_seg", 32'(seg), 32'h00);
      end
      repeat (56) @(negedge clk);

      send_frame(32'h203F, 16, 1'b1, 1'b0, "wr_d2");
      wait_dig(4'b0100, 200);
      check("d2_seg", 32'(seg), 32'h3F);
      wait_dig(4'b1000, 200);
      check("d3_seg", 32'(seg), 32'h00);

      send_frame(32'h7FFF, 15, 1'b0, 1'b1, "short15");
      send_frame(32'h0103F, 17, 1'b0, 1'b1, "long17");
      wait_dig(4'b0010, 200);
      check("d1_untouched", 32'(seg), 32'h00);
      wait_dig(4'b0100, 200);
      check("d2_kept", 32'(seg), 32'h3F);

      send_frame(32'h50FF, 16, 1'b0, 1'b1, "bad_addr");
      send_frame(32'h0, 0, 1'b0, 1'b1, "glitch0");
      send_frame(32'h0006, 16, 1'b1, 1'b0, "wr_d0");
      send_frame(32'h3E5B, 16, 1'b1, 1'b0, "wr_d3_rsvd");
      wait_dig(4'b1000, 200);
      check("d3_seg_5b", 32'(seg), 32'h5B);
      wait_dig(4'b0001, 200);
      check("d0_seg_06", 32'(seg), 32'h06);

      send_frame(32'hF000, 16, 1'b1, 1'b0, "disp_off");
      check("off_dig", 32'(dig), 32'h0);
      check("off_seg", 32'(seg), 32'h00);
      repeat (40) @(negedge clk);
      send_frame(32'hF001, 16, 1'b1, 1'b0, "disp_on");

      send_frame(32'h117F, 16, 1'b1, 1'b0, "wr_d1_blink");
      repeat (6 * N * R) @(negedge clk);

      // Reset in the middle of a frame: no pulse afterwards, RAM cleared
      cs_n = 1'b0;
      repeat (4) @(negedge clk);
      shift_bits(32'h00A5, 8);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst  = 1'b0;
      cs_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         check("abort_no_err", 32'(err), 32'h0);
      end
      wait_dig(4'b0100, 200);
      check("post_rst_d2", 32'(seg), 32'h00);
      send_frame(32'h20AA, 16, 1'b1, 1'b0, "post_rst_wr");
      wait_dig(4'b0100, 200);
      check("post_rst_d2_aa", 32'(seg), 32'hAA);

      repeat (20) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/spi_seg_mux_controller.md
# spi_seg_mux_controller

Parametrised multi-digit seven-segment display controller. Receives 16-bit SPI write frames into a per-digit segment RAM and time-multiplexes that RAM onto a shared segment bus with one-hot digit enables. It sits between the chip's dedicated SPI input pins and the display outputs, replacing the single fixed-pattern segment driver.

## Interface
- NUM_DIGITS, 4, number of multiplexed digits; legal 1..15.
- REFRESH_COUNT, 16, clk cycles each digit stays lit; legal >= 2.
- BLINK_DIV, 64, full scan rounds per blink half-period; used only with SEG_BLINK_EN.
- clk  input  1  the only clock; every flop is clocked on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- spi_sclk  input  1  SPI clock, mode 0, asynchronous to clk, at most clk/4.
- spi_cs_n  input  1  SPI chip select, active low.
- spi_mosi  input  1  SPI data, MSB first, sampled on spi_sclk rising edge.
- seg_out  output  8  active-high segments; bit 7 = dp, bits 6..0 = g..a.
- dig_en  output  NUM_DIGITS  one-hot active-high digit enable.
- frame_ok  output  1  one-cycle pulse when a valid frame is applied.
- frame_err  output  1  one-cycle pulse when a frame is discarded.

## Operation
- spi_sclk, spi_cs_n and spi_mosi each pass through a 2-flop synchronizer. The sclk and cs_n edges are detected by comparing sync stage 2 against a delayed copy.
- cs_n falling edge: clears the bit counter and the shift register.
- Each sclk rising edge while cs_n is low: shifts mosi in at the LSB. The bit counter saturates at 17.
- cs_n rising edge with exactly 16 bits received:
  - Frame fields: [15:12] address, [11:9] reserved (ignored), [8] blink flag, [7:0] segment pattern.
  - Address < NUM_DIGITS: ram[address] <= pattern; frame_ok.
  - Address 4'hF: control frame. display_en <= data[0]; frame_ok.
  - Any other address: no state change; frame_err.
- cs_n rising edge with any other bit count: frame discarded, frame_err. Counts of 0 (cs_n glitch) also raise frame_err.
- Scan: a prescaler counts 0..REFRESH_COUNT-1. At the terminal count it wraps to 0 and the digit index advances, NUM_DIGITS-1 -> 0.
- Outputs are registered from the current digit index:
  - seg_out = ram[digit].
  - dig_en = 1 << digit.
- display_en = 0: seg_out = 0 and dig_en = 0. Scanning continues, so re-enabling resumes in phase.
- A write to the digit currently displayed is visible on the next clk.
- Reset values:
  - ram all 0, display_en 1, prescaler 0, digit 0, blink state 0.
  - seg_out 0, dig_en 1 (digit 0), frame_ok 0, frame_err 0.
- A reset asserted mid-frame aborts the frame silently; no frame_err is raised. The next frame requires a fresh cs_n falling edge.

## Timing
- Pin-to-detect latency: 3 clk (two synchronizer flops plus the edge register).
- A RAM/control write and frame_ok/frame_err happen on the clk edge that detects the cs_n rise.
- seg_out/dig_en change 1 clk after a prescaler wrap or a RAM write.
- Each digit is lit exactly REFRESH_COUNT cycles. The full scan period is NUM_DIGITS*REFRESH_COUNT cycles.
- cs_n must stay high at least 4 clk between frames. Violations are not detected.

## Configuration
- SEG_BLINK_EN defined:
  - Adds a per-digit blink bit, written from frame bit 8 together with the pattern.
  - A counter of completed scan rounds toggles the blink phase every BLINK_DIV rounds.
  - During the off phase, digits with their blink bit set drive seg_out = 0; dig_en is unaffected.
  - Blink bits reset to 0 and the blink phase resets to "on".
- SEG_BLINK_EN undefined: frame bit 8 is ignored, no blink logic is built, and BLINK_DIV is unused.

## Structure
- Package seg_ctrl_pkg holds:
  - FRAME_W = 16.
  - Field positions for address, blink flag and pattern.
  - ADDR_CTRL = 4'hF.
  - The segment bit-order constants.
- Sub-module spi_frame_rx contains the synchronizers, edge detection, shift register and bit counter. It outputs frame_valid, frame_bad and the 16-bit frame. The top holds the RAM, scan logic and outputs.

## Test plan
- Reset, then hold for 2*NUM_DIGITS*REFRESH_COUNT cycles -> seg_out stays 0; dig_en steps 1,2,4,8,1 every 16 cycles; no frame pulses.
- Send 16'h2_03F -> frame_ok one cycle, 3 clk after cs_n rises; seg_out = 8'h3F exactly while dig_en = 4'b0100.
- Send a 15-bit frame, then a 17-bit frame -> frame_err pulses twice; RAM unchanged.
- Send 16'h5_0FF with NUM_DIGITS=4 -> frame_err; all RAM entries unchanged.
- Send 16'hF_000 -> dig_en = 0 and seg_out = 0 while scanning continues; send 16'hF_001 -> the digit resumes at the scan phase it would have had without the disable.
- With SEG_BLINK_EN and BLINK_DIV=2, send 16'h1_17F -> digit 1 shows 8'h7F for 2 scan rounds, then 0 for 2 rounds, repeating; the other digits are unaffected.
